// File: rtl/s_init_pkg.sv
// Shared types for the S-memory initialiser: pattern selects and sequencer states.
package s_init_pkg;

    typedef enum logic [1:0] {
        MODE_IDENT = 2'd0,
        MODE_DESC  = 2'd1,
        MODE_FILL  = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/s_array_init.sv
// Walks a shared write port over DEPTH words writing identity, descending or fill data.
// Latency: DEPTH+1 cycles from accepted start to done when the grant is held high.
// Backpressure: mem_gnt low stalls the walk; the address holds and nothing is written.
module s_array_init
    import s_init_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] fill_val,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              busy,
    output logic              done
);

    generate
        if ((DEPTH < 2) || (DEPTH > (1 << ADDR_W))) begin : g_bad_depth
            $error("s_array_init: DEPTH must be in 2..2**ADDR_W");
        end
    endgenerate

    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   LAST_W = (ADDR_W + 1)'(DEPTH - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] fill_q;
    logic [ADDR_W:0]   desc_w;
    logic [DATA_W-1:0] pat;
    logic              in_write;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            mode_q  <= '0;
            fill_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= WRITE;
                        addr_q  <= '0;
                        mode_q  <= mode;
                        fill_q  <= fill_val;
                    end
                end
                WRITE: begin
                    if (mem_gnt) begin
                        if (addr_q == LAST_A) begin
                            state_q <= DONE;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    addr_q  <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    addr_q  <= '0;
                end
            endcase
        end
    end

    // Descending value needs one extra bit so DEPTH == 2**ADDR_W cannot overflow.
    always_comb begin
        desc_w = LAST_W - {1'b0, addr_q};
        case (mode_q)
            MODE_DESC: pat = DATA_W'(desc_w);
            MODE_FILL: pat = fill_q;
            default:   pat = DATA_W'(addr_q);
        endcase
    end

    assign in_write = (state_q == WRITE);
    assign mem_req  = in_write;
    assign mem_wren = in_write & mem_gnt;
    assign mem_addr = in_write ? addr_q : '0;
    assign mem_data = in_write ? pat : '0;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_s_array_init.sv
// Scoreboard bench for s_array_init: three parameterisations driven by directed and random stimulus.
module tb_s_array_init;

    logic       clk = 1'b0;
    logic       rs  [3];
    logic       st  [3];
    logic [1:0] md  [3];
    logic [7:0] fv  [3];
    logic       gn  [3];
    logic       req [3];
    logic       wren[3];
    logic       bsy [3];
    logic       dn  [3];
    logic [7:0] adr [3];
    logic [7:0] dat [3];
    logic [3:0] dat2;

    always #5 clk = ~clk;

    s_array_init u_dut0 (
        .clk(clk), .reset(rs[0]), .start(st[0]), .mode(md[0]), .fill_val(fv[0]),
        .mem_req(req[0]), .mem_gnt(gn[0]), .mem_wren(wren[0]), .mem_addr(adr[0]),
        .mem_data(dat[0]), .busy(bsy[0]), .done(dn[0])
    );

    s_array_init #(.ADDR_W(8), .DATA_W(8), .DEPTH(10)) u_dut1 (
        .clk(clk), .reset(rs[1]), .start(st[1]), .mode(md[1]), .fill_val(fv[1]),
        .mem_req(req[1]), .mem_gnt(gn[1]), .mem_wren(wren[1]), .mem_addr(adr[1]),
        .mem_data(dat[1]), .busy(bsy[1]), .done(dn[1])
    );

    s_array_init #(.ADDR_W(8), .DATA_W(4), .DEPTH(256)) u_dut2 (
        .clk(clk), .reset(rs[2]), .start(st[2]), .mode(md[2]), .fill_val(fv[2][3:0]),
        .mem_req(req[2]), .mem_gnt(gn[2]), .mem_wren(wren[2]), .mem_addr(adr[2]),
        .mem_data(dat2), .busy(bsy[2]), .done(dn[2])
    );
    assign dat[2] = {4'h0, dat2};

    int depth_p[3] = '{256, 10, 256};
    int mask_p [3] = '{255, 255, 15};

    // Reference model: words still to write, pending done flag, expected (addr,data) queue.
    int exp_q [3][$];
    int left      [3] = '{0, 0, 0};
    bit dflag     [3] = '{0, 0, 0};
    int model_dn  [3] = '{0, 0, 0};
    int done_seen [3] = '{0, 0, 0};
    int done_cyc  [3] = '{0, 0, 0};
    int t0        [3] = '{0, 0, 0};
    int cyc_cnt = 0;
    bit armed = 0;
    int vec = 0;
    int err = 0;

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] ex);
        vec++;
        if (act !== ex) begin
            err++;
            $display("FAIL %s dut%0d cyc %0d: got %0h expected %0h", nm, i, cyc_cnt, act, ex);
        end
    endtask

    function automatic int word(int i, int k, int m, int f);
        int d;
        case (m)
            1:       d = depth_p[i] - 1 - k;
            2:       d = f;
            default: d = k;
        endcase
        return (k << 8) | (d & mask_p[i]);
    endfunction

    always @(posedge clk) begin
        cyc_cnt++;
        for (int i = 0; i < 3; i++) begin
            if (rs[i]) begin
                left[i] = 0;
                dflag[i] = 0;
                exp_q[i].delete();
            end else if (dflag[i]) begin
                dflag[i] = 0;
            end else if (left[i] > 0) begin
                if (gn[i]) begin
                    left[i]--;
                    if (left[i] == 0) begin
                        dflag[i] = 1;
                        model_dn[i]++;
                    end
                end
            end else if (st[i]) begin
                left[i] = depth_p[i];
                for (int k = 0; k < depth_p[i]; k++)
                    exp_q[i].push_back(word(i, k, int'(md[i]), int'(fv[i])));
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < 3; i++) begin
                bit er;
                er = (left[i] > 0);
                chk("busy", i, 32'(bsy[i]), 32'(er || dflag[i]));
                chk("done", i, 32'(dn[i]), 32'(dflag[i]));
                chk("req", i, 32'(req[i]), 32'(er));
                chk("wren", i, 32'(wren[i]), 32'(er && gn[i]));
                if (er) begin
                    if (exp_q[i].size() == 0) begin
                        chk("queue_underrun", i, 32'(0), 32'(1));
                    end else begin
                        chk("addr", i, 32'(adr[i]), 32'(exp_q[i][0] >> 8));
                        chk("data", i, 32'(dat[i]), 32'(exp_q[i][0] & 255));
                        if (gn[i]) void'(exp_q[i].pop_front());
                    end
                end else begin
                    chk("idle_addr", i, 32'(adr[i]), 32'(0));
                    chk("idle_data", i, 32'(dat[i]), 32'(0));
                end
                if (dn[i] === 1'b1) begin
                    done_seen[i]++;
                    done_cyc[i] = cyc_cnt;
                    chk("q_empty_at_done", i, 32'(exp_q[i].size()), 32'(0));
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int i, input logic [1:0] m, input logic [7:0] f);
        st[i] = 1'b1;
        md[i] = m;
        fv[i] = f;
        t0[i] = cyc_cnt;
        cyc();
        st[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int bound);
        int n;
        int seen0;
        n = 0;
        seen0 = done_seen[i];
        while (done_seen[i] == seen0 && n < bound) begin
            cyc();
            n++;
        end
        if (done_seen[i] == seen0) chk("done_timeout", i, 32'(0), 32'(1));
    endtask

    task automatic rand_drive(input int i, input int n);
        for (int c = 0; c < n; c++) begin
            st[i] = ($urandom_range(0, 7) == 0);
            md[i] = 2'($urandom_range(0, 3));
            fv[i] = 8'($urandom);
            gn[i] = ($urandom_range(0, 3) != 0);
            rs[i] = ($urandom_range(0, 399) == 0);
            cyc();
        end
        st[i] = 1'b0;
        rs[i] = 1'b0;
        gn[i] = 1'b1;
    endtask

    initial begin
        int base;
        int n;
        for (int i = 0; i < 3; i++) begin
            rs[i] = 1'b1; st[i] = 1'b0; md[i] = 2'd0; fv[i] = 8'h00; gn[i] = 1'b1;
        end
        cyc();
        armed = 1;
        cyc();
        for (int i = 0; i < 3; i++) rs[i] = 1'b0;
        cyc();

        // Identity, grant held: done 257 cycles after start.
        pulse_start(0, 2'd0, 8'h00);
        wait_done(0, 400);
        chk("ident_done_latency", 0, 32'(done_cyc[0] - t0[0]), 32'(257));
        cyc();

        // Fill A5 with three grant-low cycles at address 10.
        pulse_start(0, 2'd2, 8'hA5);
        for (int c = 1; c <= 14; c++) begin
            gn[0] = (c < 11 || c > 13);
            cyc();
        end
        gn[0] = 1'b1;
        wait_done(0, 400);
        chk("fill_done_latency", 0, 32'(done_cyc[0] - t0[0]), 32'(260));
        cyc();

        // DEPTH=10 descending; DATA_W=4 identity truncation.
        pulse_start(1, 2'd1, 8'h00);
        wait_done(1, 50);
        chk("desc10_done_latency", 1, 32'(done_cyc[1] - t0[1]), 32'(11));
        pulse_start(2, 2'd0, 8'h00);
        wait_done(2, 400);
        chk("trunc_done_latency", 2, 32'(done_cyc[2] - t0[2]), 32'(257));
        cyc();

        // Restart attempts while busy are ignored.
        base = done_seen[0];
        pulse_start(0, 2'd0, 8'h00);
        for (int c = 1; c <= 110; c++) begin
            st[0] = (c == 5 || c == 100);
            md[0] = (c % 2 == 0) ? 2'd2 : 2'd1;
            fv[0] = 8'(c);
            cyc();
        end
        st[0] = 1'b0;
        wait_done(0, 400);
        for (int c = 0; c < 5; c++) cyc();
        chk("single_done", 0, 32'(done_seen[0] - base), 32'(1));

        // Reset at cycle 40 mid-write, then a fresh run from address 0.
        pulse_start(0, 2'd1, 8'h00);
        for (int c = 1; c < 40; c++) cyc();
        rs[0] = 1'b1;
        cyc();
        rs[0] = 1'b0;
        chk("post_reset_busy", 0, 32'(bsy[0]), 32'(0));
        chk("post_reset_wren", 0, 32'(wren[0]), 32'(0));
        chk("post_reset_addr", 0, 32'(adr[0]), 32'(0));
        cyc();
        pulse_start(0, 2'd0, 8'h00);
        chk("restart_addr0", 0, 32'(adr[0]), 32'(0));
        wait_done(0, 400);
        cyc();

        // Random traffic on all three instances.
        fork
            rand_drive(0, 2500);
            rand_drive(1, 1500);
            rand_drive(2, 2500);
        join
        n = 0;
        while (n < 700 && (left[0] + left[1] + left[2] > 0 || dflag[0] || dflag[1] || dflag[2])) begin
            cyc();
            n++;
        end
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk("done_count", i, 32'(done_seen[i]), 32'(model_dn[i]));
            chk("final_queue", i, 32'(exp_q[i].size()), 32'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/s_array_init.md
# s_array_init

Parametrised initialiser for RC4-style state memories. On a start pulse it walks a write port across DEPTH consecutive addresses, writing an identity, descending or constant pattern, then pulses done. It sits in front of the shared S memory. It requests the write port through a simple req/gnt handshake, so it can share the port with the key-schedule and PRGA sequencers instead of owning the memory.

## Interface
Parameters:
- ADDR_W, 8: address width of the target memory.
- DATA_W, 8: data width of the target memory.
- DEPTH, 256: number of words written, addresses 0..DEPTH-1. Elaboration error if DEPTH < 2 or DEPTH > 2**ADDR_W.

Ports:
- clk, in, 1: sole clock, rising edge.
- reset, in, 1: synchronous, active-high.
- start, in, 1: single-cycle request to begin; sampled only in IDLE.
- mode, in, 2: pattern select, latched on accepted start. 0 = identity, 1 = descending, 2 = fill, 3 = reserved (treated as identity).
- fill_val, in, DATA_W: constant for fill mode, latched on accepted start.
- mem_req, out, 1: port request to the arbiter.
- mem_gnt, in, 1: port grant from the arbiter.
- mem_wren, out, 1: write enable to the memory.
- mem_addr, out, ADDR_W: write address.
- mem_data, out, DATA_W: write data.
- busy, out, 1: high whenever state is not IDLE.
- done, out, 1: one-cycle completion pulse.

## Operation
- States:
  - IDLE: start=1 goes to WRITE. Latch mode/fill_val; addr counter := 0.
  - WRITE: when mem_gnt=1, write the current word. On an edge with mem_gnt=1, if addr = DEPTH-1 go to DONE, else addr += 1. With mem_gnt=0, hold the address and do not write.
  - DONE: done=1 for this one cycle, then IDLE unconditionally.
- mem_req = (state==WRITE).
- mem_wren = (state==WRITE) & mem_gnt. This is the only combinational path from an input.
- mem_addr = addr counter, registered.
- Data rules, all widths handled explicitly:
  - identity: mem_data = addr zero-extended or truncated to DATA_W.
  - descending: mem_data = (DEPTH-1-addr), computed at ADDR_W+1 bits, then zero-extended or truncated to DATA_W.
  - fill: mem_data = latched fill_val.
- start while busy: ignored. Not queued, no error.
- mode/fill_val changes after acceptance: no effect until the next start.
- reset in any state: next cycle is IDLE. Outputs return to reset values and no further write occurs.
- Reset values: mem_req=0, mem_wren=0, mem_addr=0, mem_data=0, busy=0, done=0.
- Outside WRITE, mem_data = 0 and mem_addr = 0.

## Timing
- Cycle n: start=1 in IDLE.
- Cycle n+1: WRITE with addr=0, busy=1, mem_req=1.
- With mem_gnt held at 1: writes occur in cycles n+1..n+DEPTH, done=1 in cycle n+DEPTH+1, IDLE in cycle n+DEPTH+2.
- Each cycle with mem_gnt=0 during WRITE adds exactly one cycle to this latency.
- Back-to-back operation: a start in the cycle after done (IDLE) is accepted. A start coincident with done is ignored.
- Address never exceeds DEPTH-1; there is no wrap to 0 inside an operation.

## Structure
- Package s_init_pkg holds:
  - mode_t enum (MODE_IDENT=0, MODE_DESC=1, MODE_FILL=2).
  - state_t enum (IDLE, WRITE, DONE).
- Single module, no sub-module. The memory and the arbiter are instantiated by the parent.

## Test plan
- Defaults, identity, mem_gnt tied 1, start at cycle 0:
  - Writes observed are addr k -> data k for k=0..255 in cycles 1..256.
  - done pulses in cycle 257 only; busy is high in cycles 1..257.
- Fill mode with fill_val=8'hA5, and mem_gnt low for 3 cycles around address 10:
  - No write while gnt is low; addr holds at 10.
  - All 256 words are 8'hA5; done is late by exactly 3 cycles.
- DEPTH=10, descending:
  - Writes are 0->9, 1->8, ..., 9->0.
  - done in cycle 11; mem_addr never reaches 10.
- start re-asserted at cycles 5 and 100 during an operation, with mode and fill_val toggled:
  - No restart; pattern unchanged; exactly one done.
- reset asserted at cycle 40 mid-WRITE:
  - Cycle 41 shows all outputs zero and busy=0, with no write.
  - A new start afterwards rewrites from address 0.
- DATA_W=4, ADDR_W=8, identity:
  - Data is the address truncated to 4 bits, e.g. addr 8'h1F -> 4'hF.
